vgalb_seq: RTL
==============

# vgalb_seq

Line-buffer sequencer that owns the single port of the 1024x24 VGA line buffer (vgalb), with a 2-cycle registered read. It splits the RAM into two 512-pixel banks: it writes the incoming video line into one bank and replays the last completed line from the other, once per output line, which doubles the scan rate. It arbitrates the single RAM port between a buffered write stream and on-demand pixel reads, and returns read pixels with fixed latency.

## Interface
Parameters:
- LB_AW, 10, line-buffer address width; bit LB_AW-1 selects the bank.
- PIX_W, 24, pixel width (RGB888).

Ports:
- sys_clk  in  1  single clock for block and line buffer.
- reset  in  1  reset, synchronous and active-high.
- in_pix  in  24  incoming pixel.
- in_vld  in  1  in_pix valid this cycle.
- in_hs  in  1  one-cycle pulse: start of a new input line.
- out_hs  in  1  one-cycle pulse: start of a new output line.
- out_rdy  in  1  request for the next output pixel.
- border  in  24  colour for out-of-range reads; used only under VGALB_SEQ_BORDER_EN.
- out_pix  out  24  returned pixel.
- out_vld  out  1  out_pix valid.
- ovf  out  1  sticky flag: a write was dropped.
- lb_a  out  10  line-buffer address.
- lb_d  out  24  line-buffer write data.
- lb_we  out  1  line-buffer write enable.
- lb_q  in  24  line-buffer read data, 2 cycles after the address.

## Operation
- State:
  - wbank: write bank.
  - rbank: read bank.
  - wptr[9:0]: write pointer, saturates at 512.
  - rptr[8:0]: read pointer.
  - wlen[9:0]: length of the last completed input line.
  - rlen: wlen latched at out_hs.
  - 2-entry write FIFO of {addr[9:0], pix[23:0]}.
  - 3-stage read-valid shift register.
- in_hs:
  - wlen <= wptr.
  - wbank <= ~wbank.
  - wptr <= 0.
- in_vld:
  - If wptr < 512 and the FIFO is not full, enqueue {wbank,wptr[8:0]}, in_pix and increment wptr.
  - Otherwise drop the pixel and set ovf.
  - The address is captured at enqueue, so pending entries keep their old line's bank.
- in_hs and in_vld in the same cycle: the pixel is pixel 0 of the new line, written to the new bank at address offset 0.
- out_hs:
  - rbank <= next-value of ~wbank, i.e. it includes a simultaneous in_hs flip.
  - rlen <= next wlen.
  - rptr <= 0.
- out_hs and out_rdy in the same cycle: the request reads pixel 0 of the new output line.
- out_rdy:
  - If rptr < rlen, issue a RAM read {rbank,rptr} and increment rptr.
  - Otherwise issue no RAM access and return the fill value: black 24'h000000, or border under the macro.
  - The valid bit enters the shift register in both cases.
- Port arbitration each cycle: an in-range read wins; otherwise pop the FIFO head (lb_we=1); otherwise idle (lb_we=0).
- Sustained rate: out_rdy and in_vld are each high at most every other cycle, so nothing is dropped. A faster rate may set ovf and never corrupts reads.
- Bank tearing: if in_hs flips wbank onto the bank being read mid-line, the read shows new data. This is accepted; no interlock.
- Reset values:
  - ovf, out_vld, lb_we = 0; out_pix, lb_a, lb_d = 0.
  - wbank=0, rbank=1.
  - wlen, rlen, wptr, rptr = 0.
  - FIFO empty.
- Reset mid-line discards in-flight reads; out_vld is 0 from the next cycle on.

## Timing
- lb_a, lb_d and lb_we are registered: the arbitration decision in cycle N appears on the port in cycle N+1.
- Read latency:
  - out_rdy high in cycle N gives out_vld=1 and out_pix in cycle N+3.
  - This holds for both RAM and fill pixels.
  - Requests stay in order; out_vld has exactly one pulse per out_rdy cycle.
- Write latency: in_vld in cycle N gives lb_we at the earliest in N+2, one cycle later per competing read.
- ovf sets in the cycle after the drop and stays set until reset.

## Configuration
- VGALB_SEQ_BORDER_EN:
  - Defined: out-of-range and empty-line pixels return border, sampled in the request cycle.
  - Undefined: they return 24'h000000 and border is unused; the port remains present.

## Structure
- Shared package vgalb_pkg:
  - LB_AW=10, PIX_W=24.
  - LB_BANK_PIX=512.
  - READ_LAT=3.
  - FILL_BLACK=24'h000000.
  - typedef of the write-FIFO entry {addr, pix}.
- Sub-module vgalb_wfifo: 2-entry write FIFO with push/pop/full/empty and drop indication.

## Test plan
- After reset: out_rdy x4 gives four out_vld pulses at N+3 with out_pix=0; lb_we never asserts; ovf=0.
- One line of 320 pixels:
  - Stimulus: in_pix=index, every other cycle, then in_hs, then out_hs.
  - Expect: 320 reads return 0..319 at offsets 0..319 of bank 0; request 321 returns fill.
- Scan doubling: after the line above, two out_hs with 320 requests each; both lines return identical data.
- Contention: out_rdy and in_vld on alternating cycles give no ovf, correct write addresses, and read latency exactly 3.
- Overflow cases, each expecting ovf=1 and the RAM content of the first 512 pixels intact:
  - in_vld every cycle while out_rdy is also high every other cycle (FIFO fills, drops occur).
  - 600 pixels on one line: pixels 512..599 are dropped.
- Boundary cases:
  - in_hs with in_vld in the same cycle: the pixel lands at {new bank, 0}.
  - Reset asserted with two reads in flight: no out_vld afterward.
  - With VGALB_SEQ_BORDER_EN and border=24'h123456, reads past the line return 24'h123456.

Source files
------------

// File: rtl/vgalb_pkg.sv
// Shared constants and types for the VGA line-buffer sequencer.
package vgalb_pkg;
    localparam int LB_AW       = 10;
    localparam int PIX_W       = 24;
    localparam int LB_BANK_PIX = 512;
    localparam int READ_LAT    = 3;
    localparam logic [PIX_W-1:0] FILL_BLACK = 24'h000000;

    typedef struct packed {
        logic [LB_AW-1:0] addr;
        logic [PIX_W-1:0] pix;
    } wfifo_entry_t;
endpackage

// File: rtl/vgalb_wfifo.sv
// Two-entry write FIFO; a push while full is refused and flagged on drop.
module vgalb_wfifo
    import vgalb_pkg::*;
(
    input  logic         sys_clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  wfifo_entry_t din,
    output wfifo_entry_t dout,
    output logic         full,
    output logic         empty,
    output logic         drop
);
    wfifo_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign drop    = push && full;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/vgalb_seq.sv
// Line-buffer sequencer: ping-pong banks, write FIFO vs. read arbitration, fixed 3-cycle read return.
// Optional VGALB_SEQ_BORDER_EN returns the border colour instead of black for out-of-range reads.
module vgalb_seq #(
    parameter int LB_AW = 10,
    parameter int PIX_W = 24
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_vld,
    input  logic             in_hs,
    input  logic             out_hs,
    input  logic             out_rdy,
    input  logic [PIX_W-1:0] border,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_vld,
    output logic             ovf,
    output logic [LB_AW-1:0] lb_a,
    output logic [PIX_W-1:0] lb_d,
    output logic             lb_we,
    input  logic [PIX_W-1:0] lb_q
);
    import vgalb_pkg::*;

    localparam logic [LB_AW-1:0] BANK_PIX = LB_AW'(LB_BANK_PIX);

    logic             wbank;
    logic             rbank;
    logic [LB_AW-1:0] wptr;
    logic [LB_AW-1:0] rptr;
    logic [LB_AW-1:0] wlen;
    logic [LB_AW-1:0] rlen;
    logic [READ_LAT-1:0] vld_sr;
    logic [READ_LAT-1:0] ram_sr;

    logic             wbank_nx;
    logic [LB_AW-1:0] wptr_eff;
    logic [LB_AW-1:0] wptr_nx;
    logic [LB_AW-1:0] wlen_nx;
    logic             in_range;
    logic             push_req;
    logic             rbank_eff;
    logic [LB_AW-1:0] rlen_eff;
    logic [LB_AW-1:0] rptr_eff;
    logic [LB_AW-1:0] rptr_nx;
    logic [LB_AW-1:0] rd_addr;
    logic             rd_hit;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    wfifo_entry_t     fifo_din;
    wfifo_entry_t     fifo_head;
    logic [PIX_W-1:0] fill_pix;

    // Line starts take effect in the same cycle, so a coincident pixel or
    // request already belongs to the new line.
    always_comb begin
        wbank_nx  = wbank ^ in_hs;
        wptr_eff  = in_hs ? '0 : wptr;
        wlen_nx   = in_hs ? wptr : wlen;
        in_range  = (wptr_eff < BANK_PIX);
        push_req  = in_vld && in_range;
        fifo_din  = '{addr: {wbank_nx, wptr_eff[LB_AW-2:0]}, pix: in_pix};
        wptr_nx   = (push_req && !fifo_full) ? wptr_eff + LB_AW'(1) : wptr_eff;

        rbank_eff = out_hs ? ~wbank_nx : rbank;
        rlen_eff  = out_hs ? wlen_nx : rlen;
        rptr_eff  = out_hs ? '0 : rptr;
        rd_hit    = out_rdy && (rptr_eff < rlen_eff);
        rptr_nx   = rd_hit ? rptr_eff + LB_AW'(1) : rptr_eff;
        rd_addr   = {rbank_eff, rptr_eff[LB_AW-2:0]};
        fifo_pop  = !rd_hit && !fifo_empty;
    end

    vgalb_wfifo u_wfifo (
        .sys_clk (sys_clk),
        .reset   (reset),
        .push    (push_req),
        .pop     (fifo_pop),
        .din     (fifo_din),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .drop    (fifo_drop)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wbank  <= 1'b0;
            rbank  <= 1'b1;
            wptr   <= '0;
            rptr   <= '0;
            wlen   <= '0;
            rlen   <= '0;
            ovf    <= 1'b0;
            lb_a   <= '0;
            lb_d   <= '0;
            lb_we  <= 1'b0;
            vld_sr <= '0;
            ram_sr <= '0;
        end else begin
            wbank  <= wbank_nx;
            wptr   <= wptr_nx;
            wlen   <= wlen_nx;
            rbank  <= rbank_eff;
            rlen   <= rlen_eff;
            rptr   <= rptr_nx;
            ovf    <= ovf | (in_vld && !in_range) | fifo_drop;
            vld_sr <= {vld_sr[READ_LAT-2:0], out_rdy};
            ram_sr <= {ram_sr[READ_LAT-2:0], rd_hit};
            if (rd_hit) begin
                lb_a  <= rd_addr;
                lb_we <= 1'b0;
            end else if (fifo_pop) begin
                lb_a  <= fifo_head.addr;
                lb_d  <= fifo_head.pix;
                lb_we <= 1'b1;
            end else begin
                lb_we <= 1'b0;
            end
        end
    end

`ifdef VGALB_SEQ_BORDER_EN
    // Border colour travels alongside the request so it matches the request cycle.
    logic [PIX_W-1:0] fill_sr [READ_LAT];

    always_ff @(posedge sys_clk) begin
        fill_sr[0] <= border;
        for (int i = 1; i < READ_LAT; i++) begin
            fill_sr[i] <= fill_sr[i-1];
        end
    end

    assign fill_pix = fill_sr[READ_LAT-1];
`else
    logic unused_border;

    assign unused_border = ^border;
    assign fill_pix      = FILL_BLACK;
`endif

    assign out_vld = vld_sr[READ_LAT-1];
    assign out_pix = !vld_sr[READ_LAT-1] ? '0 :
                     ram_sr[READ_LAT-1]  ? lb_q : fill_pix;
endmodule
